// File: rtl/fetch_queue_if.sv
// Fetch queue bus: i_cache push side, decode pop side, flush and status.
// master = the i_cache/decode/redirect environment, slave = the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  i_valid;
  logic [ADDR_WIDTH-1:0] i_pc;
  logic [DATA_WIDTH-1:0] i_instr;
  logic                  o_ready;
  logic                  i_flush;
  logic                  o_valid;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic [DATA_WIDTH-1:0] o_instr;
  logic                  i_ready;
  logic [CNT_W-1:0]      o_count;
  logic                  o_overflow;

  modport master (
    output i_valid, i_pc, i_instr, i_flush, i_ready,
    input  o_ready, o_valid, o_pc, o_instr, o_count, o_overflow
  );

  modport slave (
    input  i_valid, i_pc, i_instr, i_flush, i_ready,
    output o_ready, o_valid, o_pc, o_instr, o_count, o_overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between i_cache and decode: circular buffer with
// flush, sticky overflow flag and zeroed head outputs while empty.
module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  overflow_reg;

  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);
  assign push  = bus.i_valid && !full  && !bus.i_flush;
  assign pop   = !empty && bus.i_ready && !bus.i_flush;

  // Storage is never reset; the count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= bus.i_pc;
      instr_mem[wr_ptr_reg] <= bus.i_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (bus.i_flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (bus.i_valid && full) overflow_reg <= 1'b1;
    end
  end

  // Head is read asynchronously so a push is visible right after its edge.
  assign bus.o_ready    = !full;
  assign bus.o_valid    = !empty;
  assign bus.o_pc       = empty ? '0 : pc_mem[rd_ptr_reg];
  assign bus.o_instr    = empty ? '0 : instr_mem[rd_ptr_reg];
  assign bus.o_count    = count_reg;
  assign bus.o_overflow = overflow_reg;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 26;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  entry_t model_q[$];
  logic   model_ovf = 1'b0;
  int     model_wr  = 0;
  int     model_rd  = 0;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic          ev;
    logic [AW-1:0] epc;
    logic [DW-1:0] ein;
    ev  = (model_q.size() != 0);
    epc = ev ? model_q[0].pc    : '0;
    ein = ev ? model_q[0].instr : '0;
    chk({tag, ".count"},    64'(bus.o_count),    64'(model_q.size()));
    chk({tag, ".valid"},    64'(bus.o_valid),    64'(ev));
    chk({tag, ".ready"},    64'(bus.o_ready),    64'(model_q.size() != DEPTH));
    chk({tag, ".pc"},       64'(bus.o_pc),       64'(epc));
    chk({tag, ".instr"},    64'(bus.o_instr),    64'(ein));
    chk({tag, ".overflow"}, 64'(bus.o_overflow), 64'(model_ovf));
    chk({tag, ".wr_ptr"},   64'(dut.wr_ptr_reg), 64'(model_wr));
    chk({tag, ".rd_ptr"},   64'(dut.rd_ptr_reg), 64'(model_rd));
    $display("%0t %s count=%0d valid=%0b pc=%0h ovf=%0b", $time, tag,
             bus.o_count, bus.o_valid, bus.o_pc, bus.o_overflow);
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input logic v, input logic [AW-1:0] pc, input logic fl,
                      input logic rdy, input logic rn, input string tag);
    int     sz;
    entry_t e;
    bus.i_valid = v;
    bus.i_pc    = pc;
    bus.i_instr = $urandom;
    bus.i_flush = fl;
    bus.i_ready = rdy;
    rst_n       = rn;
    sz = model_q.size();
    if (!rn) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_wr  = 0;
      model_rd  = 0;
    end else if (fl) begin
      model_q.delete();
      model_wr = 0;
      model_rd = 0;
    end else begin
      if (v && sz == DEPTH) model_ovf = 1'b1;
      if (sz > 0 && rdy) begin
        e = model_q.pop_front();
        model_rd = (model_rd + 1) % DEPTH;
      end
      if (v && sz < DEPTH) begin
        model_q.push_back({pc, bus.i_instr});
        model_wr = (model_wr + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_pc    = '0;
    bus.i_instr = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    rst_n       = 1'b0;

    step(0, 0, 0, 0, 0, "reset0");
    step(0, 0, 0, 0, 0, "reset1");

    // Three pushes without decode draining.
    step(1, 26'h0, 0, 0, 1, "push3_a");
    step(1, 26'h4, 0, 0, 1, "push3_b");
    step(1, 26'h8, 0, 0, 1, "push3_c");
    chk("push3.pc", 64'(bus.o_pc), 64'h0);

    // Fill, then push while full to raise overflow.
    step(0, 0, 1, 0, 1, "flush_pre");
    for (int i = 0; i < DEPTH; i++) step(1, AW'(26'h10 + 4 * i), 0, 0, 1, "fill");
    step(1, 26'h20, 0, 0, 1, "overflow");
    chk("overflow.flag", 64'(bus.o_overflow), 64'h1);
    step(0, 0, 0, 0, 1, "ovf_hold");

    // Reset while full and overflowed.
    step(0, 0, 0, 0, 0, "rst_full");
    chk("rst_full.ready", 64'(bus.o_ready), 64'h1);

    // Three held, then eight simultaneous push/pop cycles wrap both pointers.
    for (int i = 0; i < 3; i++) step(1, AW'(26'h200 + 4 * i), 0, 0, 1, "hold3");
    for (int i = 0; i < 8; i++) step(1, AW'(26'h300 + 4 * i), 0, 1, 1, "stream");

    // Flush with concurrent push and pop drops everything.
    step(0, 0, 1, 0, 1, "flush_clr");
    step(1, 26'h50, 0, 0, 1, "two_a");
    step(1, 26'h54, 0, 0, 1, "two_b");
    step(1, 26'h40, 1, 1, 1, "flush_push");
    chk("flush_push.pc", 64'(bus.o_pc), 64'h0);

    // Empty to one entry: valid rises only after the push edge.
    chk("latency.before", 64'(bus.o_valid), 64'h0);
    step(1, 26'h100, 0, 0, 1, "latency");
    chk("latency.after", 64'(bus.o_pc), 64'h100);

    // Random traffic including occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 3) != 0),
           AW'({$urandom_range(0, 16'hffff), 2'b00}),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 99) != 0),
           "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
